// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default
// geometry, the bubble instruction encoding, the standard channel layout
// and a channel-extraction helper for the default packing.
package pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 4;

    // Instruction word shown whenever a stage holds no valid entry.
    localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;

    // Standard channel layout: program counter, operand, branch target, instruction.
    localparam int CH_PC = 0;
    localparam int CH_O  = 1;
    localparam int CH_B  = 2;
    localparam int CH_IR = 3;

    // Return channel k of a bus packed in the default layout.
    function automatic logic [DEF_WIDTH-1:0] get_ch(
        input logic [DEF_NCH*DEF_WIDTH-1:0] bus,
        input int unsigned                  k
    );
        return bus[k*DEF_WIDTH +: DEF_WIDTH];
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one storage slot of a pipeline register, a valid bit plus a
// data word. clear wins over load so a flush always leaves the slot empty.
module pipe_slot #(
    parameter int W = 128
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid bit: set on load, dropped on clear, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Data word: captured on load only; a clear leaves it untouched because
    // the stage output mux masks it once valid drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load && !clear) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register carrying NCH channels of WIDTH
// bits, placed between processor stages.
//
// Build option: PIPE_STAGE_SKID_EN
//   defined   -> main + skid slot, in_ready is a flop output (!skid valid)
//   undefined -> single main slot, in_ready = !out_valid || out_ready
//
// Handshake: an entry moves upstream->stage on a rising edge where
// in_valid && in_ready, and stage->downstream on a rising edge where
// out_valid && out_ready. in_data is ignored unless accepted. flush empties
// the stage on its edge; anything accepted that cycle is dropped, and an
// emit that cycle still counts as delivered downstream.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                WIDTH  = DEF_WIDTH,
    parameter int                NCH    = DEF_NCH,
    parameter int                IR_CH  = CH_IR,
    parameter logic [WIDTH-1:0]  NOP_IR = WIDTH'(NOP_IR_DEFAULT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data
);

    localparam int DW = NCH * WIDTH;

    logic          main_v;
    logic [DW-1:0] main_q;
    logic [DW-1:0] main_d;
    logic          main_load;
    logic          main_clear;
    logic          accept;
    logic          emit;
    logic [DW-1:0] nop_word;

    assign accept = in_valid && in_ready;
    assign emit   = main_v && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_v;
    logic [DW-1:0] skid_q;
    logic          skid_load;
    logic          skid_clear;

    // Skid full is the only reason to refuse, so in_ready never sees out_ready.
    assign in_ready = !skid_v;

    // Slot steering: skid refills main on an emit; a new entry goes to main
    // if it is free or leaving, otherwise it parks in skid.
    always_comb begin
        main_d     = in_data;
        main_load  = 1'b0;
        main_clear = flush;
        skid_load  = 1'b0;
        skid_clear = flush;
        if (!flush) begin
            if (skid_v) begin
                if (emit) begin
                    main_load  = 1'b1;
                    main_d     = skid_q;
                    skid_clear = 1'b1;
                end
            end else if (accept) begin
                if (!main_v || emit) begin
                    main_load = 1'b1;
                end else begin
                    skid_load = 1'b1;
                end
            end else if (emit) begin
                main_clear = 1'b1;
            end
        end
    end

    pipe_slot #(.W(DW)) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .valid (skid_v),
        .q     (skid_q)
    );
`else
    // Single slot: accept whenever the slot is empty or draining this cycle.
    assign in_ready = !main_v || out_ready;

    // Load on accept (a same-cycle emit is replaced in place); empty on a
    // lone emit or a flush.
    always_comb begin
        main_d     = in_data;
        main_load  = accept && !flush;
        main_clear = flush || (emit && !accept);
    end
`endif

    pipe_slot #(.W(DW)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    // Bubble word: NOP in the instruction channel, zero everywhere else.
    always_comb begin
        nop_word                          = '0;
        nop_word[IR_CH*WIDTH +: WIDTH]    = NOP_IR;
    end

    assign out_valid = main_v;
    assign out_data  = main_v ? main_q : nop_word;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random phase, all
// checked every cycle against a queue model of the stage's contents.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW  = 128;
    localparam int SDW = 32;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           s_in_ready;
    logic           s_out_valid;
    logic [SDW-1:0] s_out_data;

    pipe_stage_reg dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    pipe_stage_reg #(.WIDTH(16), .NCH(2), .IR_CH(1), .NOP_IR(16'hFFFF)) dut_s (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data[SDW-1:0]),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data)
    );

    // Clock and counters
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of held entries, capacity 2 with skid, 1 without.
    logic [DW-1:0] mq[$];
    bit m_acc, m_emt;

    function automatic bit model_in_ready(input logic ordy);
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || ordy;
    endfunction

    function automatic logic [DW-1:0] model_out();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    function automatic logic [SDW-1:0] model_sout();
        return (mq.size() > 0) ? mq[0][SDW-1:0] : 32'hFFFF_0000;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            m_acc = in_valid && model_in_ready(out_ready);
            m_emt = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_emt) void'(mq.pop_front());
                if (m_acc) mq.push_back(in_data);
            end
        end
    end

    // Compare process: every falling edge out of reset
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            check("out_valid",   DW'(out_valid),   DW'(mq.size() > 0));
            check("out_data",    out_data,         model_out());
            check("in_ready",    DW'(in_ready),    DW'(model_in_ready(out_ready)));
            check("s_out_valid", DW'(s_out_valid), DW'(mq.size() > 0));
            check("s_out_data",  DW'(s_out_data),  DW'(model_sout()));
            check("s_in_ready",  DW'(s_in_ready),  DW'(model_in_ready(out_ready)));
        end
    end

    // Downstream log of delivered PCs
    logic [31:0] emitted[$];
    always @(negedge clock) begin
        if (reset === 1'b1 && out_valid && out_ready)
            emitted.push_back(get_ch(out_data, CH_PC));
    end

    // Driver: apply one cycle of inputs (called just after a rising edge)
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl,
                        output logic acc, output logic ov, output logic [DW-1:0] od);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        acc = in_valid && in_ready;
        ov  = out_valid;
        od  = out_data;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        return {$urandom(), $urandom(), $urandom(), pc};
    endfunction

    initial begin
        logic          acc, ov;
        logic [DW-1:0] od;
        int            idx, cnt, guard;
        logic [31:0]   pcs[3];
        logic          bub_ov[5];
        logic [31:0]   bub_in[5];

        // Reset state
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data",  out_data, '0);
        check("rst_s_out_data", DW'(s_out_data), DW'(32'hFFFF_0000));
        check("rst_in_ready",  DW'(in_ready), DW'(1));
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rel_in_ready", DW'(in_ready), DW'(1));
        @(posedge clock);
        #1;

        // Streaming 16 beats at full rate
        emitted.delete();
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tick(1'b1, mk(32'h100 + i), 1'b1, 1'b0, acc, ov, od);
            else        tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
            if (ov) cnt++;
        end
        check("stream_valid_cycles", DW'(cnt), DW'(16));
        check("stream_count", DW'(emitted.size()), DW'(16));
        for (int i = 0; i < 16 && i < emitted.size(); i++)
            check($sformatf("stream_pc%0d", i), DW'(emitted[i]), DW'(32'h100 + i));

        // Asynchronous reset with an entry held
        tick(1'b1, mk(32'h180), 1'b0, 1'b0, acc, ov, od);
        check("pre_reset_valid", DW'(out_valid), DW'(1));
        #2;
        reset = 1'b0;
        #1;
        check("async_out_valid", DW'(out_valid), DW'(0));
        check("async_out_data",  out_data, '0);
        check("async_s_out_data", DW'(s_out_data), DW'(32'hFFFF_0000));
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("async_rel_in_ready", DW'(in_ready), DW'(1));
        tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);

        // Stall for 3 cycles while offering 0x200, 0x204, 0x208
        emitted.delete();
        pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, mk(pcs[idx]), 1'b0, 1'b0, acc, ov, od);
            if (acc) idx++;
        end
        check("stall_accepted", DW'(idx), DW'(SKID ? 2 : 1));
        check("stall_third_refused", DW'(acc), DW'(0));
        guard = 0;
        while (idx < 3 && guard < 10) begin
            tick(1'b1, mk(pcs[idx]), 1'b1, 1'b0, acc, ov, od);
            if (acc) idx++;
            guard++;
        end
        check("stall_all_accepted", DW'(idx), DW'(3));
        for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
        check("stall_count", DW'(emitted.size()), DW'(3));
        for (int i = 0; i < 3 && i < emitted.size(); i++)
            check($sformatf("stall_pc%0d", i), DW'(emitted[i]), DW'(pcs[i]));

        // Flush with the stage full and downstream stalled
        emitted.delete();
        for (int k = 0; k < 2; k++) tick(1'b1, mk(32'h280 + 4 * k), 1'b0, 1'b0, acc, ov, od);
        tick(1'b1, mk(32'h300), 1'b0, 1'b1, acc, ov, od);
        tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
        check("flush_next_valid", DW'(ov), DW'(0));
        check("flush_next_ir", DW'(get_ch(od, CH_IR)), DW'(NOP_IR_DEFAULT));
        check("flush_next_data", od, '0);
        for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
        check("flush_nothing_emitted", DW'(emitted.size()), DW'(0));

        // Flush on a cycle that both emits and accepts
        emitted.delete();
        tick(1'b1, mk(32'h310), 1'b1, 1'b0, acc, ov, od);
        tick(1'b1, mk(32'h314), 1'b1, 1'b1, acc, ov, od);
        check("flushB_handshake", DW'(acc), DW'(1));
        tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
        check("flushB_next_valid", DW'(ov), DW'(0));
        for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
        check("flushB_count", DW'(emitted.size()), DW'(1));
        if (emitted.size() > 0) check("flushB_pc", DW'(emitted[0]), DW'(32'h310));

        // Bubble: in_valid 1,0,1 at full rate
        emitted.delete();
        bub_in[0] = 32'h400; bub_in[1] = 0; bub_in[2] = 32'h404; bub_in[3] = 0; bub_in[4] = 0;
        bub_ov[0] = 0; bub_ov[1] = 1; bub_ov[2] = 0; bub_ov[3] = 1; bub_ov[4] = 0;
        for (int i = 0; i < 5; i++) begin
            tick(bub_in[i] != 0, mk(bub_in[i]), 1'b1, 1'b0, acc, ov, od);
            check($sformatf("bubble_valid%0d", i), DW'(ov), DW'(bub_ov[i]));
            if (i == 2) check("bubble_nop_word", od, '0);
        end
        check("bubble_count", DW'(emitted.size()), DW'(2));
        if (emitted.size() == 2) begin
            check("bubble_pc0", DW'(emitted[0]), DW'(32'h400));
            check("bubble_pc1", DW'(emitted[1]), DW'(32'h404));
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) < 7, mk($urandom()), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 24) == 0, acc, ov, od);
        end
        for (int c = 0; c < 4; c++) tick(1'b0, '0, 1'b1, 1'b0, acc, ov, od);
        check("drained_valid", DW'(out_valid), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
